// File: rtl/reg_line_formatter_pkg.sv
// Shared constants, state encoding and nibble helper for the register line formatter.
package reg_line_formatter_pkg;

    localparam logic [7:0] CH_R       = 8'd52;
    localparam logic [7:0] CH_COLON   = 8'd53;
    localparam logic [7:0] CH_SPACE   = 8'd63;
    localparam int         LINE_CHARS = 12;
    localparam logic [3:0] LAST_COL   = 4'd11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        EMIT     = 2'd2,
        LINE_END = 2'd3
    } state_t;

    // Column 4 shows bits [31:28], column 11 shows bits [3:0].
    function automatic logic [3:0] nibble_at(input logic [31:0] value, input logic [3:0] col);
        logic [2:0] sel;
        sel = 3'(LAST_COL - col);
        return value[{sel, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/reg_line_formatter_if.sv
// Character stream from the formatter to the VGA register-display drawer.
interface reg_line_formatter_if #(
    parameter int ROW_W = 3
) ();
    logic [7:0]       char_code;
    logic [3:0]       char_col;
    logic [ROW_W-1:0] char_row;
    logic             char_valid;
    logic             char_ready;

    modport master (
        output char_code, char_col, char_row, char_valid,
        input  char_ready
    );

    modport slave (
        input  char_code, char_col, char_row, char_valid,
        output char_ready
    );
endinterface

// File: rtl/reg_line_formatter_hex_line_mux.sv
// Maps a column of a register text line to its character code.
module hex_line_mux
    import reg_line_formatter_pkg::*;
(
    input  logic [31:0] value,
    input  logic [3:0]  reg_index,
    input  logic [3:0]  col,
    output logic [7:0]  char_code
);

    // Column-to-character selection.
    always_comb begin
        char_code = 8'd0;
        case (col)
            4'd0:    char_code = CH_R;
            4'd1:    char_code = {4'd0, reg_index};
            4'd2:    char_code = CH_COLON;
            4'd3:    char_code = CH_SPACE;
            4'd4, 4'd5, 4'd6, 4'd7,
            4'd8, 4'd9, 4'd10, 4'd11:
                     char_code = {4'd0, nibble_at(value, col)};
            default: char_code = 8'd0;
        endcase
    end

endmodule

// File: rtl/reg_line_formatter.sv
// Walks the register file and streams one "Rn: XXXXXXXX" line of character codes per register.
module reg_line_formatter
    import reg_line_formatter_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int ROW_W    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                auto_refresh,
    output logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   register_value,
    reg_line_formatter_if.master chars,
    output logic                finished_register,
    output logic                frame_done,
    output logic                busy
);

    localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(NUM_REGS - 1);
    localparam logic [2:0]       LAT      = 3'(READ_LAT);

    state_t              state_r, state_next;
    logic [ROW_W-1:0]    idx_r, idx_next;
    logic [3:0]          col_r, col_next;
    logic [2:0]          wait_r, wait_next;
    logic [DATA_W-1:0]   value_r, value_next;
    logic                accept_s;
    logic [7:0]          code_s;

    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          char_code_r;
    logic [3:0]          char_col_r;
    logic [ROW_W-1:0]    char_row_r;
    logic                char_valid_r;
    logic                finished_r;
    logic                frame_done_r;
    logic                busy_r;

    assign accept_s = char_valid_r && chars.char_ready;

    // Next-state, index, column, wait counter and value latch.
    always_comb begin
        state_next = state_r;
        idx_next   = idx_r;
        col_next   = col_r;
        wait_next  = wait_r;
        value_next = value_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    idx_next   = '0;
                    wait_next  = 3'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            FETCH: begin
                if (wait_r == LAT) begin
                    value_next = register_value;
                    col_next   = 4'd0;
                    state_next = EMIT;
                end else begin
                    wait_next = wait_r + 3'd1;
                end
            end
            EMIT: begin
                if (accept_s) begin
                    if (col_r == LAST_COL) begin
                        state_next = LINE_END;
                    end else begin
                        col_next = col_r + 4'd1;
                    end
                end else begin
                    state_next = EMIT;
                end
            end
            LINE_END: begin
                wait_next = 3'd0;
                if (idx_r == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = auto_refresh ? FETCH : IDLE;
                end else begin
                    idx_next   = idx_r + ROW_W'(1);
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Character for the cycle after this edge, computed from next-state values so outputs stay registered.
    hex_line_mux u_mux (
        .value     (value_next[31:0]),
        .reg_index (4'(idx_next)),
        .col       (col_next),
        .char_code (code_s)
    );

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            col_r        <= 4'd0;
            wait_r       <= 3'd0;
            value_r      <= '0;
            addr_r       <= '0;
            char_code_r  <= 8'd0;
            char_col_r   <= 4'd0;
            char_row_r   <= '0;
            char_valid_r <= 1'b0;
            finished_r   <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next;
            idx_r        <= idx_next;
            col_r        <= col_next;
            wait_r       <= wait_next;
            value_r      <= value_next;
            if (state_next == FETCH) begin
                addr_r <= ADDR_W'(idx_next);
            end
            char_valid_r <= (state_next == EMIT);
            char_code_r  <= (state_next == EMIT) ? code_s : 8'd0;
            char_col_r   <= (state_next == EMIT) ? col_next : 4'd0;
            char_row_r   <= idx_next;
            finished_r   <= (state_next == LINE_END);
            frame_done_r <= (state_next == LINE_END) && (idx_next == LAST_IDX);
            busy_r       <= (state_next != IDLE);
        end
    end

    assign addr              = addr_r;
    assign chars.char_code   = char_code_r;
    assign chars.char_col    = char_col_r;
    assign chars.char_row    = char_row_r;
    assign chars.char_valid  = char_valid_r;
    assign finished_register = finished_r;
    assign frame_done        = frame_done_r;
    assign busy              = busy_r;

endmodule

// File: tb/tb_reg_line_formatter.sv
// Directed self-checking bench for reg_line_formatter (READ_LAT=1 main instance, READ_LAT=3 latency instance).
module tb_reg_line_formatter;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, start3, auto_refresh, auto_refresh3;
    logic [8:0]  addr, addr3;
    logic [31:0] register_value, register_value3;
    logic        fin, fd, busy, fin3, fd3, busy3;
    logic [31:0] regs [0:15];

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_code [$];
    logic [3:0] cap_col  [$];
    logic [2:0] cap_row  [$];
    int fin_cnt, fd_cnt, stall_viol, addr_viol;

    always #5 clock = ~clock;

    assign register_value  = regs[addr[3:0]];
    assign register_value3 = regs[addr3[3:0]];

    reg_line_formatter_if #(.ROW_W(3)) cif  ();
    reg_line_formatter_if #(.ROW_W(3)) cif3 ();

    reg_line_formatter #(.NUM_REGS(8), .ADDR_W(9), .DATA_W(32), .READ_LAT(1), .ROW_W(3)) dut (
        .clock(clock), .reset(reset), .start(start), .auto_refresh(auto_refresh),
        .addr(addr), .register_value(register_value), .chars(cif),
        .finished_register(fin), .frame_done(fd), .busy(busy)
    );

    reg_line_formatter #(.NUM_REGS(8), .ADDR_W(9), .DATA_W(32), .READ_LAT(3), .ROW_W(3)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .auto_refresh(auto_refresh3),
        .addr(addr3), .register_value(register_value3), .chars(cif3),
        .finished_register(fin3), .frame_done(fd3), .busy(busy3)
    );

    function automatic logic [7:0] exp_char(input int idx, input logic [31:0] v, input int col);
        case (col)
            0:       return 8'd52;
            1:       return 8'(idx);
            2:       return 8'd53;
            3:       return 8'd63;
            default: return 8'((v >> (4 * (11 - col))) & 32'hF);
        endcase
    endfunction

    // Drives char_ready and records accepted characters; stops on line count, a stop point, or budget.
    task automatic capture(input int max_lines, input int stop_row, input int stop_col, input int mode,
                           input int chg_row, input logic [31:0] chg_val, input int budget);
        int stall_left;
        logic pend, r, changed;
        logic [7:0] pc;
        logic [3:0] pcol;
        logic [2:0] prow;
        cap_code.delete(); cap_col.delete(); cap_row.delete();
        fin_cnt = 0; fd_cnt = 0; stall_viol = 0; addr_viol = 0;
        stall_left = 0; pend = 1'b0; changed = 1'b0;
        pc = 8'd0; pcol = 4'd0; prow = 3'd0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clock);
            if (fin) fin_cnt++;
            if (fd) fd_cnt++;
            if (pend && (!cif.char_valid || cif.char_code !== pc || cif.char_col !== pcol || cif.char_row !== prow))
                stall_viol++;
            if (cif.char_valid && addr !== {6'd0, cif.char_row}) addr_viol++;
            if (fin_cnt >= max_lines) break;
            if (cif.char_valid && int'(cif.char_row) == stop_row && int'(cif.char_col) == stop_col) break;
            if (!changed && chg_row >= 0 && cif.char_valid && int'(cif.char_row) == chg_row && cif.char_col == 4'd5) begin
                regs[chg_row] = chg_val;
                changed = 1'b1;
            end
            if (mode == 0) begin
                r = 1'b1;
            end else if (stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end else if (cif.char_valid && $urandom_range(0, 1) == 1) begin
                r = 1'b0;
                stall_left = 2;
            end else begin
                r = 1'b1;
            end
            cif.char_ready = r;
            if (cif.char_valid && r) begin
                cap_code.push_back(cif.char_code);
                cap_col.push_back(cif.char_col);
                cap_row.push_back(cif.char_row);
            end
            pend = cif.char_valid && !r;
            pc = cif.char_code; pcol = cif.char_col; prow = cif.char_row;
        end
        cif.char_ready = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start3 = 1'b0; auto_refresh = 1'b0; auto_refresh3 = 1'b0;
        cif.char_ready = 1'b0; cif3.char_ready = 1'b0;
        for (int k = 0; k < 16; k++) regs[k] = 32'd0;
        repeat (3) @(negedge clock);
        checks++; if (addr !== 9'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
        checks++; if (cif.char_code !== 8'd0) begin errors++; $display("FAIL reset_code got %0d want 0", cif.char_code); end
        checks++; if (cif.char_col !== 4'd0) begin errors++; $display("FAIL reset_col got %0d want 0", cif.char_col); end
        checks++; if (cif.char_row !== 3'd0) begin errors++; $display("FAIL reset_row got %0d want 0", cif.char_row); end
        checks++; if (cif.char_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", cif.char_valid); end
        checks++; if (fin !== 1'b0) begin errors++; $display("FAIL reset_finished got %0d want 0", fin); end
        checks++; if (fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0d want 0", fd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy); end
        reset = 1'b0;
    endtask

    task automatic test_first_line();
        logic [7:0] exp_line [12];
        exp_line = '{8'd52, 8'd0, 8'd53, 8'd63, 8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd11, 8'd12, 8'd13};
        regs[0] = 32'h1234ABCD;
        for (int k = 1; k < 8; k++) regs[k] = 32'h0000_0010 * k;
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat1_busy got %0d want 1", busy); end
        checks++; if (cif.char_valid !== 1'b0) begin errors++; $display("FAIL lat1_valid_t got %0d want 0", cif.char_valid); end
        @(negedge clock);
        checks++; if (cif.char_valid !== 1'b0) begin errors++; $display("FAIL lat1_valid_t1 got %0d want 0", cif.char_valid); end
        checks++; if (addr !== 9'd0) begin errors++; $display("FAIL lat1_addr got %0d want 0", addr); end
        @(negedge clock);
        checks++; if (cif.char_valid !== 1'b1 || cif.char_code !== 8'd52) begin
            errors++; $display("FAIL lat1_valid_t2 got valid=%0d code=%0d want valid=1 code=52", cif.char_valid, cif.char_code); end
        capture(1, -1, -1, 0, -1, 32'd0, 100);
        checks++; if (cap_code.size() !== 12) begin errors++; $display("FAIL line0_len got %0d want 12", cap_code.size()); end
        for (int i = 0; i < 12 && i < cap_code.size(); i++) begin
            checks++;
            if (cap_code[i] !== exp_line[i] || cap_col[i] !== 4'(i)) begin
                errors++; $display("FAIL line0_char%0d got code=%0d col=%0d want code=%0d col=%0d", i, cap_code[i], cap_col[i], exp_line[i], i);
            end
        end
        checks++; if (fin_cnt !== 1) begin errors++; $display("FAIL line0_finished got %0d want 1", fin_cnt); end
        checks++; if (addr_viol !== 0) begin errors++; $display("FAIL line0_addr got %0d bad cycles want 0", addr_viol); end
        capture(7, -1, -1, 0, -1, 32'd0, 400);
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL drain_frame_done got %0d want 1", fd_cnt); end
    endtask

    task automatic check_frame(input string name, input logic [31:0] vals [8]);
        checks++; if (cap_code.size() !== 96) begin errors++; $display("FAIL %s_len got %0d want 96", name, cap_code.size()); end
        for (int i = 0; i < cap_code.size() && i < 96; i++) begin
            checks++;
            if (cap_code[i] !== exp_char(i / 12, vals[i / 12], i % 12) || cap_col[i] !== 4'(i % 12) || cap_row[i] !== 3'(i / 12)) begin
                errors++;
                $display("FAIL %s_char%0d got code=%0d col=%0d row=%0d want code=%0d col=%0d row=%0d", name, i,
                         cap_code[i], cap_col[i], cap_row[i], exp_char(i / 12, vals[i / 12], i % 12), i % 12, i / 12);
            end
        end
    endtask

    task automatic test_full_frame();
        logic [31:0] vals [8];
        for (int k = 0; k < 8; k++) begin regs[k] = 32'h11111111 * k; vals[k] = regs[k]; end
        pulse_start();
        capture(8, -1, -1, 0, -1, 32'd0, 400);
        check_frame("frame", vals);
        checks++; if (fin_cnt !== 8) begin errors++; $display("FAIL frame_finished got %0d want 8", fin_cnt); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL frame_done_cnt got %0d want 1", fd_cnt); end
        checks++; if (addr_viol !== 0) begin errors++; $display("FAIL frame_addr got %0d bad cycles want 0", addr_viol); end
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after got %0d want 0", busy); end
    endtask

    task automatic test_stall();
        logic [31:0] vals [8];
        for (int k = 0; k < 8; k++) begin regs[k] = 32'hA5000000 + 32'h01030507 * k; vals[k] = regs[k]; end
        pulse_start();
        capture(8, -1, -1, 1, -1, 32'd0, 2000);
        check_frame("stall", vals);
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stall_viol); end
        checks++; if (fin_cnt !== 8) begin errors++; $display("FAIL stall_finished got %0d want 8", fin_cnt); end
    endtask

    task automatic test_value_change();
        logic [31:0] vals [8];
        for (int k = 0; k < 8; k++) begin regs[k] = 32'h0F1E2D3C ^ (32'h10101010 * k); vals[k] = regs[k]; end
        pulse_start();
        capture(8, -1, -1, 0, 2, 32'hDEADBEEF, 400);
        check_frame("latch", vals);
        // READ_LAT=3 instance: first char_valid after the fourth edge following start.
        @(negedge clock);
        start3 = 1'b1;
        @(negedge clock);
        start3 = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            @(negedge clock);
            checks++; if (cif3.char_valid !== 1'b0) begin errors++; $display("FAIL lat3_valid_t%0d got %0d want 0", d, cif3.char_valid); end
        end
        @(negedge clock);
        checks++; if (cif3.char_valid !== 1'b1 || cif3.char_code !== 8'd52 || cif3.char_row !== 3'd0) begin
            errors++; $display("FAIL lat3_valid_t4 got valid=%0d code=%0d row=%0d want 1 52 0", cif3.char_valid, cif3.char_code, cif3.char_row); end
    endtask

    task automatic test_auto_refresh();
        logic [31:0] vals [8];
        for (int k = 0; k < 8; k++) begin regs[k] = 32'h76543210 + k; vals[k] = regs[k]; end
        auto_refresh = 1'b1;
        pulse_start();
        capture(8, -1, -1, 0, -1, 32'd0, 400);
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL auto_frame_done got %0d want 1", fd_cnt); end
        checks++; if (addr !== 9'd7) begin errors++; $display("FAIL auto_addr_last got %0d want 7", addr); end
        @(negedge clock);
        checks++; if (addr !== 9'd0 || busy !== 1'b1 || cif.char_row !== 3'd0) begin
            errors++; $display("FAIL auto_restart got addr=%0d busy=%0d row=%0d want 0 1 0", addr, busy, cif.char_row); end
        auto_refresh = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        capture(8, -1, -1, 0, -1, 32'd0, 400);
        check_frame("auto", vals);
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL auto_second_done got %0d want 1", fd_cnt); end
        repeat (4) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_ignored got %0d want 0", busy); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 8; k++) regs[k] = 32'hCAFE0000 + k;
        pulse_start();
        capture(8, 5, 3, 0, -1, 32'd0, 400);
        checks++; if (cap_code.size() !== 63) begin errors++; $display("FAIL mid_progress got %0d want 63", cap_code.size()); end
        reset = 1'b1;
        #1;
        checks++; if (cif.char_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_drop got valid=%0d busy=%0d want 0 0", cif.char_valid, busy); end
        @(negedge clock);
        reset = 1'b0;
        pulse_start();
        checks++; if (addr !== 9'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_restart_addr got addr=%0d busy=%0d want 0 1", addr, busy); end
        repeat (2) @(negedge clock);
        checks++; if (cif.char_valid !== 1'b1 || cif.char_row !== 3'd0 || cif.char_code !== 8'd52) begin
            errors++; $display("FAIL mid_restart_char got valid=%0d row=%0d code=%0d want 1 0 52", cif.char_valid, cif.char_row, cif.char_code); end
        capture(8, -1, -1, 0, -1, 32'd0, 400);
        checks++; if (cap_code.size() !== 96 || fd_cnt !== 1) begin
            errors++; $display("FAIL mid_restart_frame got chars=%0d done=%0d want 96 1", cap_code.size(), fd_cnt); end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_full_frame();
        test_stall();
        test_value_change();
        test_auto_refresh();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
